// File: rtl/audio_gen_pkg.sv
// Shared definitions for the procedural audio tone source: sample-rate and
// datapath widths, the note descriptor, the player state encoding and a helper
// that converts a frequency in Hz into a phase increment.
package audio_gen_pkg;

  localparam int unsigned FS      = 12500;
  localparam int          SAMP_W  = 16;
  localparam int          PHASE_W = 24;
  localparam int          DUR_W   = 16;

  localparam logic signed [SAMP_W-1:0] AMP_DEFAULT = 16'sh2000;

  typedef struct packed {
    logic [PHASE_W-1:0] inc;
    logic [DUR_W-1:0]   dur;
  } note_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } tone_state_e;

  // round(freq_hz * 2^PHASE_W / FS), computed in 64-bit integer arithmetic.
  function automatic logic [PHASE_W-1:0] note_inc(input int unsigned freq_hz);
    longint unsigned num;
    num = longint'(freq_hz) << PHASE_W;
    return PHASE_W'((num + longint'(FS / 2)) / longint'(FS));
  endfunction

endpackage

// File: rtl/tone_wave_lut.sv
// Combinational phase -> PCM sample mapping.
// Default build: square wave of +/-AMP, 0 for a rest.
// With AUDIO_TONE_TRIANGLE_EN defined: non-rest notes produce a triangle wave.
module tone_wave_lut
  import audio_gen_pkg::*;
#(
  parameter logic signed [SAMP_W-1:0] AMP = AMP_DEFAULT
) (
  input  logic [PHASE_W-1:0]        phase,
  input  logic                      rest,
  output logic signed [SAMP_W-1:0]  sample
);

`ifdef AUDIO_TONE_TRIANGLE_EN
  logic [SAMP_W-2:0]        p;
  logic [SAMP_W-2:0]        t;
  logic signed [SAMP_W-1:0] centered;
  logic signed [SAMP_W-1:0] doubled;
  logic                     unused_low_phase;

  // Fold the phase into a rising/falling ramp, centre it on zero, scale it.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    p        = phase[PHASE_W-2 -: SAMP_W-1];
    t        = phase[PHASE_W-1] ? ~p : p;
    centered = $signed({1'b0, t}) - $signed(SAMP_W'(1 << (SAMP_W-2)));
    doubled  = centered <<< 1;
    sample   = '0;
    if (!rest) begin
      sample = doubled >>> 2;
    end
  end

  assign unused_low_phase = ^phase[PHASE_W-SAMP_W-1:0];
`else
  logic unused_low_phase;

  // Square wave: phase MSB selects the polarity, rests are silent.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sample = '0;
    if (!rest) begin
      sample = phase[PHASE_W-1] ? -AMP : AMP;
    end
  end

  assign unused_low_phase = ^phase[PHASE_W-2:0];
`endif

endmodule

// File: rtl/audio_tone_gen.sv
// Note-driven PCM tone source. Accepts (phase increment, duration) notes and
// emits one signed sample per samp_tick through a valid/ready handshake.
// Optional triangle waveform: define AUDIO_TONE_TRIANGLE_EN.
module audio_tone_gen
  import audio_gen_pkg::*;
#(
  parameter logic signed [SAMP_W-1:0] AMP = AMP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      samp_tick,
  input  logic                      note_valid,
  output logic                      note_ready,
  input  logic [PHASE_W-1:0]        note_inc,
  input  logic [DUR_W-1:0]          note_dur,
  output logic                      samp_valid,
  input  logic                      samp_ready,
  output logic signed [SAMP_W-1:0]  samp_data,
  output logic                      busy,
  output logic                      overrun,
  output logic [31:0]               samp_count
);

  tone_state_e              state;
  logic [PHASE_W-1:0]       phase;
  logic [PHASE_W-1:0]       inc_q;
  logic [DUR_W-1:0]         dur_cnt;
  logic signed [SAMP_W-1:0] wave;

  tone_wave_lut #(
    .AMP (AMP)
  ) u_lut (
    .phase  (phase),
    .rest   (inc_q == '0),
    .sample (wave)
  );

  assign note_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Note player: accept a note, generate one sample per tick, hold it until
  // downstream takes it, and track overruns and the handshaked sample count.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      inc_q      <= '0;
      dur_cnt    <= '0;
      samp_valid <= 1'b0;
      samp_data  <= '0;
      overrun    <= 1'b0;
      samp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length notes are accepted and dropped without leaving IDLE.
          if (note_valid && note_dur != '0) begin
            inc_q   <= note_inc;
            dur_cnt <= note_dur;
            phase   <= '0;
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (samp_tick) begin
            samp_data  <= wave;
            phase      <= phase + inc_q;
            samp_valid <= 1'b1;
            dur_cnt    <= dur_cnt - DUR_W'(1);
            state      <= HOLD;
          end
        end
        HOLD: begin
          // A tick while a sample is pending is lost, not deferred.
          if (samp_tick) begin
            overrun <= 1'b1;
          end
          if (samp_ready) begin
            samp_valid <= 1'b0;
            samp_count <= samp_count + 32'd1;
            state      <= (dur_cnt == '0) ? IDLE : PLAY;
          end
        end
        default: begin
          state      <= IDLE;
          samp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
